// File: rtl/fpga_io_apb_arbiter.sv
// Round-robin arbiter that sequences two hold-until-done requesters onto one APB
// master port, returning per-requester read data and error status with a wait timeout.
module fpga_io_apb_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic              busy,
    output logic [1:0]        gnt
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t            state_reg, state_next;
    logic              last_grant_reg, last_grant_next;
    logic              owner_reg, owner_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
    logic              pwrite_reg, pwrite_next;
    logic [ADDR_W-1:0] paddr_reg, paddr_next;
    logic [DATA_W-1:0] pwdata_reg, pwdata_next;
    logic              psel_reg, psel_next;
    logic              penable_reg, penable_next;
    logic              busy_reg, busy_next;
    logic [1:0]        gnt_reg, gnt_next;
    logic [1:0]        done_reg, done_next;
    logic [1:0]        err_reg, err_next;
    logic [DATA_W-1:0] rdata_reg [2];
    logic [DATA_W-1:0] rdata_next [2];
    logic              pick;

    logic [1:0]        req;
    logic [1:0]        cmd_write;
    logic [ADDR_W-1:0] cmd_addr [2];
    logic [DATA_W-1:0] cmd_wdata [2];

    assign req          = {m1_req, m0_req};
    assign cmd_write    = {m1_write, m0_write};
    assign cmd_addr[0]  = m0_addr;
    assign cmd_addr[1]  = m1_addr;
    assign cmd_wdata[0] = m0_wdata;
    assign cmd_wdata[1] = m1_wdata;
    assign cnt_inc      = cnt_reg + CNT_W'(1);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            cnt_reg        <= '0;
            pwrite_reg     <= 1'b0;
            paddr_reg      <= '0;
            pwdata_reg     <= '0;
            psel_reg       <= 1'b0;
            penable_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            gnt_reg        <= 2'b00;
            done_reg       <= 2'b00;
            err_reg        <= 2'b00;
            rdata_reg[0]   <= '0;
            rdata_reg[1]   <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            owner_reg      <= owner_next;
            cnt_reg        <= cnt_next;
            pwrite_reg     <= pwrite_next;
            paddr_reg      <= paddr_next;
            pwdata_reg     <= pwdata_next;
            psel_reg       <= psel_next;
            penable_reg    <= penable_next;
            busy_reg       <= busy_next;
            gnt_reg        <= gnt_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            rdata_reg[0]   <= rdata_next[0];
            rdata_reg[1]   <= rdata_next[1];
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        owner_next      = owner_reg;
        cnt_next        = cnt_reg;
        pwrite_next     = pwrite_reg;
        paddr_next      = paddr_reg;
        pwdata_next     = pwdata_reg;
        done_next       = 2'b00;
        err_next        = err_reg;
        rdata_next      = rdata_reg;
        pick            = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req != 2'b00) begin
                    // On a tie the requester that was not served last wins.
                    pick            = (req == 2'b11) ? ~last_grant_reg : req[1];
                    owner_next      = pick;
                    last_grant_next = pick;
                    pwrite_next     = cmd_write[pick];
                    paddr_next      = cmd_addr[pick];
                    pwdata_next     = cmd_wdata[pick];
                    cnt_next        = '0;
                    state_next      = SETUP;
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    state_next           = DONE;
                    done_next[owner_reg] = 1'b1;
                    err_next[owner_reg]  = PSLVERR;
                    if (!pwrite_reg) begin
                        rdata_next[owner_reg] = PRDATA;
                    end
                end else begin
                    cnt_next = cnt_inc;
                    // The counter includes the current low-ready cycle.
                    if (TIMEOUT != 0 && cnt_inc == CNT_LIMIT) begin
                        state_next            = DONE;
                        done_next[owner_reg]  = 1'b1;
                        err_next[owner_reg]   = 1'b1;
                        rdata_next[owner_reg] = '0;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        psel_next    = (state_next == SETUP) || (state_next == ACCESS);
        penable_next = (state_next == ACCESS);
        busy_next    = (state_next != IDLE);
        gnt_next     = (state_next == IDLE) ? 2'b00 : (owner_next ? 2'b10 : 2'b01);
    end

    assign PSEL     = psel_reg;
    assign PENABLE  = penable_reg;
    assign PWRITE   = pwrite_reg;
    assign PADDR    = paddr_reg;
    assign PWDATA   = pwdata_reg;
    assign busy     = busy_reg;
    assign gnt      = gnt_reg;
    assign m0_done  = done_reg[0];
    assign m1_done  = done_reg[1];
    assign m0_err   = err_reg[0];
    assign m1_err   = err_reg[1];
    assign m0_rdata = rdata_reg[0];
    assign m1_rdata = rdata_reg[1];

endmodule

// File: tb/tb_fpga_io_apb_arbiter.sv
// Scoreboard bench: requester drivers push expected results computed from a reference
// memory; a monitor pops and compares on every done pulse and checks the APB command.
module tb_fpga_io_apb_arbiter;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b1;
    logic              m0_req, m0_write, m1_req, m1_write;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_done, m0_err, m1_done, m1_err;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              PSEL, PENABLE, PWRITE, PREADY, PSLVERR, busy;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA, PRDATA;
    logic [1:0]        gnt;

    always #5 PCLK = ~PCLK;

    fpga_io_apb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .busy(busy), .gnt(gnt)
    );

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } exp_t;

    exp_t              exp_q0[$];
    exp_t              exp_q1[$];
    int                checks = 0;
    int                fails = 0;
    int                fixed_waits = -1;
    logic [DATA_W-1:0] ref_mem [1024];
    logic [DATA_W-1:0] slv_mem [1024];
    logic [DATA_W-1:0] held [2];
    int                acc_cnt = 0;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic              s_wr;

    function automatic logic [DATA_W-1:0] mem_init(int i);
        return (i == 2) ? 32'h3 : (32'(i) * 32'h9E3779B1);
    endfunction

    // Slave behaviour: ready after wait_of() low ACCESS cycles, error on addr[4:3]==11.
    function automatic int wait_of(logic [ADDR_W-1:0] a);
        return (fixed_waits >= 0) ? fixed_waits : int'(a[7:5]);
    endfunction

    function automatic logic err_of(logic [ADDR_W-1:0] a);
        return a[4:3] == 2'b11;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Reference model: a transfer times out once the slave would need TIMEOUT or more
    // low-ready cycles; reads return memory, writes keep the previously held rdata.
    task automatic expect_push(int m, logic wr, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] wd);
        exp_t e;
        e.wr = wr; e.addr = a; e.wdata = wd;
        if (wait_of(a) >= TIMEOUT) begin
            e.err = 1'b1; e.rdata = '0;
        end else begin
            e.err   = err_of(a);
            e.rdata = wr ? held[m] : ref_mem[a];
            if (wr && !e.err) ref_mem[a] = wd;
        end
        held[m] = e.rdata;
        if (m == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    endtask

    task automatic set_cmd(int m, logic r, logic wr, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] wd);
        if (m == 0) begin m0_req = r; m0_write = wr; m0_addr = a; m0_wdata = wd; end
        else        begin m1_req = r; m1_write = wr; m1_addr = a; m1_wdata = wd; end
    endtask

    task automatic set_req(int m, logic r);
        if (m == 0) m0_req = r; else m1_req = r;
    endtask

    task automatic do_single(int m, logic wr, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] wd);
        int cyc;
        logic d;
        expect_push(m, wr, a, wd);
        set_cmd(m, 1'b1, wr, a, wd);
        cyc = 0;
        d = 1'b0;
        while (!d && cyc < 200) begin
            @(negedge PCLK);
            cyc++;
            d = (m == 0) ? m0_done : m1_done;
        end
        checks++;
        if (!d) begin
            fails++;
            $display("FAIL m%0d_done_timeout: got no done in %0d cycles, expected a done", m, cyc);
        end
        set_req(m, 1'b0);
    endtask

    task automatic run_master(int m, int n);
        logic [ADDR_W-1:0] a;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge PCLK);
            a = (ADDR_W'($urandom) & 10'h3FE) | ADDR_W'(m);
            do_single(m, 1'($urandom_range(0, 1)), a, $urandom);
        end
    endtask

    task automatic check_done(int m);
        exp_t e;
        logic [DATA_W-1:0] rd;
        logic er;
        int qs;
        rd = (m == 0) ? m0_rdata : m1_rdata;
        er = (m == 0) ? m0_err : m1_err;
        check($sformatf("m%0d_done_gnt", m), 32'(gnt), (m == 0) ? 32'd1 : 32'd2);
        qs = (m == 0) ? exp_q0.size() : exp_q1.size();
        if (qs == 0) begin
            checks++; fails++;
            $display("FAIL m%0d_done_unexpected: got done pulse, expected none", m);
        end else begin
            if (m == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
            check($sformatf("m%0d_rdata", m), rd, e.rdata);
            check($sformatf("m%0d_err", m), 32'(er), 32'(e.err));
            $display("m%0d %s addr=0x%03h rdata=0x%08h err=%0b", m, e.wr ? "WR" : "RD", e.addr, rd, er);
        end
    endtask

    // APB slave with its own memory
    initial begin
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        forever begin
            @(negedge PCLK);
            if (PSEL && PENABLE) acc_cnt++; else acc_cnt = 0;
            if (PSEL && PENABLE && acc_cnt == wait_of(PADDR) + 1) begin
                PREADY  = 1'b1;
                PRDATA  = slv_mem[PADDR];
                PSLVERR = err_of(PADDR);
                if (PWRITE && !err_of(PADDR)) slv_mem[PADDR] = PWDATA;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: command checked at SETUP against the grantee's queue head, held through ACCESS
    initial begin
        forever begin
            @(negedge PCLK);
            if (!PRESET) begin
                if (PSEL && !PENABLE) begin
                    check("setup_gnt_onehot", 32'(gnt == 2'b01 || gnt == 2'b10), 32'd1);
                    if ((gnt[1] ? exp_q1.size() : exp_q0.size()) == 0) begin
                        checks++; fails++;
                        $display("FAIL setup_unexpected: got SETUP for gnt=%b, expected no transfer", gnt);
                    end else begin
                        exp_t e;
                        e = gnt[1] ? exp_q1[0] : exp_q0[0];
                        check("setup_paddr", 32'(PADDR), 32'(e.addr));
                        check("setup_pwrite", 32'(PWRITE), 32'(e.wr));
                        check("setup_pwdata", PWDATA, e.wdata);
                    end
                    s_addr = PADDR; s_wdata = PWDATA; s_wr = PWRITE;
                end else if (PSEL && PENABLE) begin
                    check("access_paddr_stable", 32'(PADDR), 32'(s_addr));
                    check("access_pwdata_stable", PWDATA, s_wdata);
                    check("access_pwrite_stable", 32'(PWRITE), 32'(s_wr));
                end
                if (m0_done) check_done(0);
                if (m1_done) check_done(1);
            end
        end
    end

    initial begin
        int n, cyc, pen, dn, got;
        int gorder[$];
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = mem_init(i);
            slv_mem[i] = mem_init(i);
        end
        held[0] = '0; held[1] = '0;
        set_cmd(0, 1'b0, 1'b0, '0, '0);
        set_cmd(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge PCLK);

        check("rst_psel", 32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_pwrite", 32'(PWRITE), 32'd0);
        check("rst_paddr", 32'(PADDR), 32'd0);
        check("rst_pwdata", PWDATA, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'({m1_done, m0_done}), 32'd0);
        check("rst_err", 32'({m1_err, m0_err}), 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        check("rst_m1_rdata", m1_rdata, 32'd0);
        PRESET = 1'b0;
        @(negedge PCLK);

        // Both requesters held for four transfers: strict alternation starting at m0
        fixed_waits = 0;
        expect_push(0, 1'b0, 10'h004, 32'h11); expect_push(0, 1'b0, 10'h004, 32'h11);
        expect_push(1, 1'b0, 10'h005, 32'h22); expect_push(1, 1'b0, 10'h005, 32'h22);
        set_cmd(0, 1'b1, 1'b0, 10'h004, 32'h11);
        set_cmd(1, 1'b1, 1'b0, 10'h005, 32'h22);
        n = 0; cyc = 0;
        while (n < 4 && cyc < 60) begin
            @(negedge PCLK);
            cyc++;
            if (PSEL && !PENABLE) gorder.push_back(int'(gnt));
            if (m0_done || m1_done) n++;
            if (n == 4) begin set_req(0, 1'b0); set_req(1, 1'b0); end
        end
        set_req(0, 1'b0); set_req(1, 1'b0);
        check("rr_transfers", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            got = (i < gorder.size()) ? gorder[i] : 0;
            check($sformatf("rr_grant%0d", i), 32'(got), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        @(negedge PCLK);
        check("rr_busy_after", 32'(busy), 32'd0);

        // Zero-wait read latency
        expect_push(0, 1'b0, 10'h002, 32'h0);
        set_cmd(0, 1'b1, 1'b0, 10'h002, 32'h0);
        @(negedge PCLK);
        check("lat_psel_t1", 32'({PSEL, PENABLE}), 32'b10);
        check("lat_gnt_t1", 32'(gnt), 32'd1);
        check("lat_busy_t1", 32'(busy), 32'd1);
        @(negedge PCLK);
        check("lat_penable_t2", 32'({PSEL, PENABLE}), 32'b11);
        @(negedge PCLK);
        check("lat_done_t3", 32'(m0_done), 32'd1);
        check("lat_bus_idle_t3", 32'({PSEL, PENABLE}), 32'b00);
        set_req(0, 1'b0);
        @(negedge PCLK);
        check("lat_done_pulse", 32'(m0_done), 32'd0);
        check("lat_busy_t4", 32'(busy), 32'd0);
        check("lat_rdata_held", m0_rdata, 32'h3);

        // m1 write with three wait states
        fixed_waits = 3;
        expect_push(1, 1'b1, 10'h013, 32'h2AA);
        set_cmd(1, 1'b1, 1'b1, 10'h013, 32'h2AA);
        pen = 0; dn = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge PCLK);
            if (PENABLE) pen++;
            if (PSEL) check("wr_pwdata_stable", PWDATA, 32'h2AA);
            if (m1_done) begin dn++; set_req(1, 1'b0); end
        end
        check("wr_penable_cycles", 32'(pen), 32'd4);
        check("wr_done_count", 32'(dn), 32'd1);

        // Timeout: PREADY never arrives
        fixed_waits = 7;
        expect_push(0, 1'b0, 10'h000, 32'h0);
        set_cmd(0, 1'b1, 1'b0, 10'h000, 32'h0);
        pen = 0; cyc = 0;
        while (!m0_done && cyc < 30) begin
            @(negedge PCLK);
            cyc++;
            if (PENABLE) pen++;
        end
        set_req(0, 1'b0);
        check("to_done_seen", 32'(m0_done), 32'd1);
        check("to_penable_cycles", 32'(pen), 32'(TIMEOUT));
        check("to_busy_in_done", 32'(busy), 32'd1);
        @(negedge PCLK);
        check("to_busy_after", 32'(busy), 32'd0);
        check("to_err_held", 32'(m0_err), 32'd1);

        // Slave error, then a clean transfer clears err
        fixed_waits = 1;
        do_single(0, 1'b0, 10'h018, 32'h0);
        fixed_waits = 0;
        do_single(0, 1'b0, 10'h000, 32'h0);

        // Asynchronous reset in ACCESS
        fixed_waits = 7;
        expect_push(0, 1'b0, 10'h008, 32'h0);
        set_cmd(0, 1'b1, 1'b0, 10'h008, 32'h0);
        cyc = 0;
        while (!PENABLE && cyc < 20) begin
            @(negedge PCLK);
            cyc++;
        end
        check("arst_in_access", 32'(PENABLE), 32'd1);
        #2 PRESET = 1'b1;
        #1;
        check("arst_bus", 32'({PSEL, PENABLE}), 32'd0);
        check("arst_gnt", 32'(gnt), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        set_req(0, 1'b0);
        exp_q0.delete(); exp_q1.delete();
        held[0] = '0; held[1] = '0;
        @(negedge PCLK);
        check("arst_no_done", 32'({m1_done, m0_done}), 32'd0);
        PRESET = 1'b0;
        fixed_waits = 0;
        expect_push(0, 1'b0, 10'h006, 32'h0);
        expect_push(1, 1'b0, 10'h007, 32'h0);
        set_cmd(0, 1'b1, 1'b0, 10'h006, 32'h0);
        set_cmd(1, 1'b1, 1'b0, 10'h007, 32'h0);
        @(negedge PCLK);
        check("arst_tie_m0", 32'(gnt), 32'd1);
        cyc = 0;
        while ((m0_req || m1_req) && cyc < 40) begin
            @(negedge PCLK);
            cyc++;
            if (m0_done) set_req(0, 1'b0);
            if (m1_done) set_req(1, 1'b0);
        end
        check("arst_both_served", 32'({m1_req, m0_req}), 32'd0);

        // Randomised concurrent traffic
        fixed_waits = -1;
        fork
            run_master(0, 25);
            run_master(1, 25);
        join
        repeat (5) @(negedge PCLK);
        check("q0_drained", 32'(exp_q0.size()), 32'd0);
        check("q1_drained", 32'(exp_q1.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
